// File: rtl/qupls_branch_miss_seq_pkg.sv
// Shared types for the branch-miss recovery sequencer: recovery FSM encoding,
// the extended PC carried with a miss, and the reset PC.
package qupls_branch_miss_seq_pkg;

  // The stomp block range-checks CHKPT_RESTORE..DONE2, so this order is fixed.
  typedef enum logic [2:0] {
    BS_IDLE           = 3'd0,
    BS_CAPTURE_MISSPC = 3'd1,
    BS_CHKPT_RESTORE  = 3'd2,
    BS_CHKPT_RESTORED = 3'd3,
    BS_STATE3         = 3'd4,
    BS_DONE           = 3'd5,
    BS_DONE2          = 3'd6
  } branch_state_t;

  typedef struct packed {
    logic [5:0]  bno_t;
    logic [5:0]  bno_f;
    logic [31:0] pc;
  } pc_address_ex_t;

  localparam logic [31:0] RSTPC = 32'hFFFD_0000;
  localparam pc_address_ex_t RST_MISSPC = '{bno_t: 6'd1, bno_f: 6'd0, pc: RSTPC};

endpackage

// File: rtl/qupls_branch_miss_seq_if.sv
// Branch-unit mispredict reports plus the checkpoint-restore handshake with the
// rename map. The sequencer uses the slave modport.
interface qupls_branch_miss_seq_if #(
  parameter int NBRU = 2,
  parameter int ROBW = 5,
  parameter int CKW  = 4
);
  import qupls_branch_miss_seq_pkg::*;

  logic [NBRU-1:0]           bru_v;
  logic [NBRU-1:0]           bru_miss;
  logic [NBRU-1:0][ROBW-1:0] bru_robid;
  logic [NBRU-1:0][CKW-1:0]  bru_cndx;
  pc_address_ex_t [NBRU-1:0] bru_tgt;
  logic                      restore_req;
  logic [CKW-1:0]            restore_cndx;
  logic                      restore_ack;

  modport master (
    output bru_v, bru_miss, bru_robid, bru_cndx, bru_tgt, restore_ack,
    input  restore_req, restore_cndx
  );

  modport slave (
    input  bru_v, bru_miss, bru_robid, bru_cndx, bru_tgt, restore_ack,
    output restore_req, restore_cndx
  );

endinterface

// File: rtl/qupls_rob_age_sel.sv
// N-way oldest-entry select by ROB age relative to the head; the wrap-around
// subtraction makes the head itself age 0. Equal ages go to the lowest index.
module qupls_rob_age_sel #(
  parameter int N    = 2,
  parameter int ROBW = 5,
  parameter int IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic [ROBW-1:0]        head,
  input  logic [N-1:0]           v,
  input  logic [N-1:0][ROBW-1:0] id,
  output logic                   vld,
  output logic [IW-1:0]          idx
);

  logic [N-1:0][ROBW-1:0] age_w;
  logic [ROBW-1:0]        best_age;

  always_comb begin
    for (int i = 0; i < N; i++) age_w[i] = id[i] - head;
  end

  always_comb begin
    vld      = 1'b0;
    idx      = '0;
    best_age = '1;
    for (int i = 0; i < N; i++) begin
      if (v[i] && (!vld || age_w[i] < best_age)) begin
        vld      = 1'b1;
        idx      = IW'(i);
        best_age = age_w[i];
      end
    end
  end

endmodule

// File: rtl/qupls_branch_miss_seq.sv
// Branch-miss recovery sequencer: picks the oldest mispredict, publishes the
// miss to stomp/fetch, and walks the checkpoint restore handshake.
module qupls_branch_miss_seq
  import qupls_branch_miss_seq_pkg::*;
#(
  parameter int NBRU        = 2,
  parameter int ROB_ENTRIES = 32,
  parameter int NCHKPT      = 16,
  localparam int ROBW = $clog2(ROB_ENTRIES),
  localparam int CKW  = $clog2(NCHKPT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ROBW-1:0]               rob_head,
  qupls_branch_miss_seq_if.slave        bru,
  input  logic                          advance_pipeline,
  output logic                          branchmiss,
  output pc_address_ex_t                misspc,
  output logic [ROBW-1:0]               miss_robid,
  output branch_state_t                 branch_state,
  output logic                          busy,
  output logic [31:0]                   miss_count
);

  localparam int CIW = (NBRU > 1) ? $clog2(NBRU) : 1;

  branch_state_t  state_q, state_d;
  pc_address_ex_t misspc_q, misspc_d, pend_tgt_q, pend_tgt_d, cand_tgt, ld_tgt;
  logic [ROBW-1:0] miss_robid_q, miss_robid_d, pend_robid_q, pend_robid_d, cand_robid, ld_robid;
  logic [CKW-1:0]  restore_cndx_q, restore_cndx_d, pend_cndx_q, pend_cndx_d, cand_cndx, ld_cndx;
  logic            branchmiss_q, branchmiss_d, restore_req_q, restore_req_d, pend_v_q, pend_v_d;
  logic [31:0]     miss_count_q, miss_count_d;

  logic           cand_v, cand_older, cand_gv, sel_v, sel_idx, load;
  logic [CIW-1:0] cand_idx;

  function automatic logic [ROBW-1:0] rob_age(input logic [ROBW-1:0] id, input logic [ROBW-1:0] head);
    return id - head;
  endfunction

  qupls_rob_age_sel #(.N(NBRU), .ROBW(ROBW), .IW(CIW)) u_cand_sel (
    .head (rob_head),
    .v    (bru.bru_v & bru.bru_miss),
    .id   (bru.bru_robid),
    .vld  (cand_v),
    .idx  (cand_idx)
  );

  assign cand_robid = bru.bru_robid[cand_idx];
  assign cand_cndx  = bru.bru_cndx[cand_idx];
  assign cand_tgt   = bru.bru_tgt[cand_idx];
  assign cand_older = cand_v && (rob_age(cand_robid, rob_head) < rob_age(miss_robid_q, rob_head));
  // Outside IDLE only a candidate older than the active miss survives; the rest are already stomped.
  assign cand_gv    = cand_v && ((state_q == BS_IDLE) || cand_older);

  qupls_rob_age_sel #(.N(2), .ROBW(ROBW), .IW(1)) u_pend_sel (
    .head (rob_head),
    .v    ({cand_gv, pend_v_q}),
    .id   ({cand_robid, pend_robid_q}),
    .vld  (sel_v),
    .idx  (sel_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= BS_IDLE;
      misspc_q       <= RST_MISSPC;
      miss_robid_q   <= '0;
      restore_cndx_q <= '0;
      branchmiss_q   <= 1'b0;
      restore_req_q  <= 1'b0;
      miss_count_q   <= '0;
      pend_v_q       <= 1'b0;
      pend_tgt_q     <= '0;
      pend_robid_q   <= '0;
      pend_cndx_q    <= '0;
    end else begin
      state_q        <= state_d;
      misspc_q       <= misspc_d;
      miss_robid_q   <= miss_robid_d;
      restore_cndx_q <= restore_cndx_d;
      branchmiss_q   <= branchmiss_d;
      restore_req_q  <= restore_req_d;
      miss_count_q   <= miss_count_d;
      pend_v_q       <= pend_v_d;
      pend_tgt_q     <= pend_tgt_d;
      pend_robid_q   <= pend_robid_d;
      pend_cndx_q    <= pend_cndx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BS_IDLE:           if (sel_v) state_d = BS_CAPTURE_MISSPC;
      BS_CAPTURE_MISSPC: if (!cand_older) state_d = BS_CHKPT_RESTORE;
      BS_CHKPT_RESTORE:  if (bru.restore_ack) state_d = BS_CHKPT_RESTORED;
      BS_CHKPT_RESTORED: state_d = BS_STATE3;
      BS_STATE3:         if (advance_pipeline) state_d = BS_DONE;
      BS_DONE:           state_d = BS_DONE2;
      BS_DONE2:          state_d = BS_IDLE;
      default:           state_d = BS_IDLE;
    endcase
  end

  always_comb begin
    misspc_d       = misspc_q;
    miss_robid_d   = miss_robid_q;
    restore_cndx_d = restore_cndx_q;
    miss_count_d   = miss_count_q;
    pend_v_d       = pend_v_q;
    pend_tgt_d     = pend_tgt_q;
    pend_robid_d   = pend_robid_q;
    pend_cndx_d    = pend_cndx_q;
    branchmiss_d   = 1'b0;
    restore_req_d  = (state_d == BS_CHKPT_RESTORE);
    load           = 1'b0;
    ld_tgt         = cand_tgt;
    ld_robid       = cand_robid;
    ld_cndx        = cand_cndx;
    case (state_q)
      BS_IDLE: begin
        if (sel_v) begin
          load     = 1'b1;
          pend_v_d = 1'b0;
          if (!sel_idx) begin
            ld_tgt   = pend_tgt_q;
            ld_robid = pend_robid_q;
            ld_cndx  = pend_cndx_q;
          end
        end
      end
      BS_CAPTURE_MISSPC: load = cand_older;
      BS_CHKPT_RESTORE, BS_CHKPT_RESTORED, BS_STATE3, BS_DONE, BS_DONE2: begin
        if (sel_v && sel_idx) begin
          pend_v_d     = 1'b1;
          pend_tgt_d   = cand_tgt;
          pend_robid_d = cand_robid;
          pend_cndx_d  = cand_cndx;
        end
      end
      default: ;
    endcase
    if (load) begin
      misspc_d       = ld_tgt;
      miss_robid_d   = ld_robid;
      restore_cndx_d = ld_cndx;
      branchmiss_d   = 1'b1;
      if (miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
    end
  end

  assign branchmiss       = branchmiss_q;
  assign misspc           = misspc_q;
  assign miss_robid       = miss_robid_q;
  assign branch_state     = state_q;
  assign busy             = (state_q != BS_IDLE);
  assign miss_count       = miss_count_q;
  assign bru.restore_req  = restore_req_q;
  assign bru.restore_cndx = restore_cndx_q;

endmodule

// File: tb/tb_qupls_branch_miss_seq.sv
// Directed bench for the branch-miss sequencer; a monitor checks every
// branchmiss pulse against expectations queued by the stimulus.
module tb_qupls_branch_miss_seq;
  import qupls_branch_miss_seq_pkg::*;

  localparam int NBRU = 2;
  localparam int ROBW = 5;
  localparam int CKW  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           advance_pipeline = 1'b1;
  logic [ROBW-1:0] rob_head = '0;
  logic           branchmiss, busy;
  pc_address_ex_t misspc;
  logic [ROBW-1:0] miss_robid;
  branch_state_t  branch_state;
  logic [31:0]    miss_count;

  qupls_branch_miss_seq_if #(.NBRU(NBRU), .ROBW(ROBW), .CKW(CKW)) bif ();

  qupls_branch_miss_seq #(.NBRU(NBRU), .ROB_ENTRIES(32), .NCHKPT(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .rob_head         (rob_head),
    .bru              (bif),
    .advance_pipeline (advance_pipeline),
    .branchmiss       (branchmiss),
    .misspc           (misspc),
    .miss_robid       (miss_robid),
    .branch_state     (branch_state),
    .busy             (busy),
    .miss_count       (miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     pc;
    logic [ROBW-1:0] robid;
    logic [CKW-1:0]  cndx;
    logic [31:0]     cnt;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input logic [ROBW-1:0] id, input logic [CKW-1:0] cx, input logic [31:0] pc);
    bif.bru_v[p]     = 1'b1;
    bif.bru_miss[p]  = 1'b1;
    bif.bru_robid[p] = id;
    bif.bru_cndx[p]  = cx;
    bif.bru_tgt[p]   = '{bno_t: 6'd0, bno_f: 6'd0, pc: pc};
  endtask

  task automatic clear_bru();
    bif.bru_v    = '0;
    bif.bru_miss = '0;
  endtask

  task automatic expect_miss(input logic [31:0] pc, input logic [ROBW-1:0] id, input logic [CKW-1:0] cx, input logic [31:0] cnt);
    exp_t e;
    e.pc = pc; e.robid = id; e.cndx = cx; e.cnt = cnt;
    sbq.push_back(e);
  endtask

  // Called with the DUT in CAPTURE_MISSPC; walks it back to IDLE, optionally
  // presenting one extra miss on port 1 when the given state is reached.
  task automatic recover(input int ack_wait, input bit inj, input logic [2:0] inj_st,
                         input logic [ROBW-1:0] inj_id, input logic [31:0] inj_pc);
    bit         injected;
    logic [2:0] es;
    logic       er;
    injected = 1'b0;
    tick();
    for (int i = 0; i < ack_wait + 4; i++) begin
      es = (i < ack_wait) ? 3'd2 : 3'(i - ack_wait + 3);
      er = (i < ack_wait);
      chk("branch_state", branch_state, es);
      chk("restore_req", bif.restore_req, er);
      bif.restore_ack = (i == ack_wait - 1);
      if (inj && !injected && es == inj_st) begin
        send(1, inj_id, 4'd2, inj_pc);
        injected = 1'b1;
      end
      tick();
      clear_bru();
    end
    bif.restore_ack = 1'b0;
    chk("idle_after_done2", branch_state, BS_IDLE);
    chk("busy_idle", busy, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst && branchmiss) begin
      if (sbq.size() == 0) begin
        chk("unexpected_branchmiss", {63'd0, branchmiss}, 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("misspc", misspc.pc, mon_e.pc);
        chk("miss_robid", miss_robid, mon_e.robid);
        chk("restore_cndx", bif.restore_cndx, mon_e.cndx);
        chk("miss_count", miss_count, mon_e.cnt);
      end
    end
  end

  initial begin
    bif.restore_ack = 1'b0;
    bif.bru_robid   = '0;
    bif.bru_cndx    = '0;
    bif.bru_tgt     = '0;
    clear_bru();
    tick();
    tick();
    chk("rst_state", branch_state, 3'd0);
    chk("rst_branchmiss", branchmiss, 1'b0);
    chk("rst_restore_req", bif.restore_req, 1'b0);
    chk("rst_restore_cndx", bif.restore_cndx, 4'd0);
    chk("rst_miss_robid", miss_robid, 5'd0);
    chk("rst_misspc", misspc.pc, 32'hFFFD_0000);
    chk("rst_bno_t", misspc.bno_t, 6'd1);
    chk("rst_bno_f", misspc.bno_f, 6'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_miss_count", miss_count, 32'd0);
    rst = 1'b0;
    tick();

    // Single miss, ack after three request cycles.
    rob_head = 5'd0;
    send(0, 5'd5, 4'd3, 32'h1000);
    expect_miss(32'h1000, 5'd5, 4'd3, 32'd1);
    tick(); clear_bru();
    chk("t1_capture", branch_state, 3'd1);
    chk("t1_busy", busy, 1'b1);
    recover(3, 1'b0, 3'd0, '0, '0);

    // Two misses across the ROB wrap: robid 31 is older than robid 2.
    rob_head = 5'd30;
    send(0, 5'd2, 4'd1, 32'h2000);
    send(1, 5'd31, 4'd7, 32'h3100);
    expect_miss(32'h3100, 5'd31, 4'd7, 32'd2);
    tick(); clear_bru();
    chk("t2_capture", branch_state, 3'd1);
    recover(1, 1'b0, 3'd0, '0, '0);

    // Younger miss during restore is dropped.
    rob_head = 5'd8;
    send(0, 5'd10, 4'd4, 32'h4000);
    expect_miss(32'h4000, 5'd10, 4'd4, 32'd3);
    tick(); clear_bru();
    chk("t3_capture", branch_state, 3'd1);
    recover(2, 1'b1, 3'd2, 5'd12, 32'h4C00);
    tick();
    chk("t3_stay_idle", branch_state, 3'd0);
    chk("t3_count", miss_count, 32'd3);

    // Older miss at STATE3 goes pending and is replayed after one IDLE cycle.
    send(0, 5'd10, 4'd5, 32'h5000);
    expect_miss(32'h5000, 5'd10, 4'd5, 32'd4);
    expect_miss(32'h9000, 5'd9, 4'd2, 32'd5);
    tick(); clear_bru();
    chk("t4_capture", branch_state, 3'd1);
    recover(1, 1'b1, 3'd4, 5'd9, 32'h9000);
    tick();
    chk("t4_replay_capture", branch_state, 3'd1);
    recover(1, 1'b0, 3'd0, '0, '0);
    chk("t4_count", miss_count, 32'd5);

    // Older miss while in CAPTURE re-arms the capture and pulses again.
    send(0, 5'd10, 4'd6, 32'h6000);
    expect_miss(32'h6000, 5'd10, 4'd6, 32'd6);
    tick(); clear_bru();
    chk("t5_capture", branch_state, 3'd1);
    send(0, 5'd9, 4'd8, 32'h6900);
    expect_miss(32'h6900, 5'd9, 4'd8, 32'd7);
    tick(); clear_bru();
    chk("t5_capture_held", branch_state, 3'd1);
    recover(2, 1'b0, 3'd0, '0, '0);

    // Reset mid-restore with a pending miss; a late ack must be ignored.
    rob_head = 5'd0;
    send(0, 5'd3, 4'd9, 32'h7000);
    expect_miss(32'h7000, 5'd3, 4'd9, 32'd8);
    tick(); clear_bru();
    chk("t6_capture", branch_state, 3'd1);
    tick();
    chk("t6_restore", branch_state, 3'd2);
    chk("t6_req", bif.restore_req, 1'b1);
    send(1, 5'd1, 4'd10, 32'h7100);
    tick(); clear_bru();
    chk("t6_still_restore", branch_state, 3'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_state", branch_state, 3'd0);
    chk("t6_rst_req", bif.restore_req, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_branchmiss", branchmiss, 1'b0);
    chk("t6_rst_count", miss_count, 32'd0);
    chk("t6_rst_misspc", misspc.pc, 32'hFFFD_0000);
    bif.restore_ack = 1'b1;
    tick();
    bif.restore_ack = 1'b0;
    chk("t6_ack_ignored", branch_state, 3'd0);
    tick();
    chk("t6_pending_cleared", branch_state, 3'd0);
    chk("t6_req_low", bif.restore_req, 1'b0);
    tick();

    chk("sb_drained", sbq.size(), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/qupls_branch_miss_seq.md
Name: qupls_branch_miss_seq

Overview:
Branch-miss recovery sequencer; the initiator side of the pipeline stomp protocol. Collects mispredict reports from branch units, picks the oldest, and publishes branchmiss, misspc and branch_state to the stomp block and fetch. Sequences checkpoint restore with a req/ack handshake to the rename map. Sits between the branch units / ROB and the front-end stomp and PC logic.

Parameters:
NBRU, 2, number of branch-unit report ports (1..4)
ROB_ENTRIES, 32, ROB depth; ROBW = $clog2(ROB_ENTRIES)
NCHKPT, 16, checkpoint count; CKW = $clog2(NCHKPT)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rob_head  in  ROBW  current ROB head index (oldest entry)
bru_v  in  NBRU  branch result valid, per unit
bru_miss  in  NBRU  result is a mispredict, per unit
bru_robid  in  NBRU*ROBW  ROB id of the branch
bru_cndx  in  NBRU*CKW  checkpoint index taken at the branch
bru_tgt  in  NBRU*pc_address_ex_t  corrected PC
advance_pipeline  in  1  front-end advance strobe
restore_ack  in  1  map restore complete
branchmiss  out  1  one-cycle miss pulse
misspc  out  pc_address_ex_t  corrected PC, held until next miss
miss_robid  out  ROBW  ROB id of the active miss (younger entries are invalidated by the ROB)
branch_state  out  branch_state_t  recovery FSM state
restore_req  out  1  checkpoint restore request
restore_cndx  out  CKW  checkpoint to restore
busy  out  1  branch_state != BS_IDLE
miss_count  out  32  saturating count of accepted misses

Behaviour:
- Reset: branch_state=BS_IDLE, branchmiss=0, restore_req=0, restore_cndx=0, miss_robid=0, misspc.pc=RSTPC, bno_t=1, bno_f=0, busy=0, miss_count=0, pending slot empty. Reset mid-recovery aborts to BS_IDLE the next cycle with no further outputs.
- Age: age(id) = (id - rob_head) mod ROB_ENTRIES, ROBW-bit wrap subtraction; smaller is older. Ties (equal id) resolve to the lowest port index.
- Candidate: ports with bru_v & bru_miss; the oldest candidate is selected combinationally each cycle.
- States (encoding order is fixed, because the stomp block range-checks CHKPT_RESTORE..DONE2): BS_IDLE=0, BS_CAPTURE_MISSPC=1, BS_CHKPT_RESTORE=2, BS_CHKPT_RESTORED=3, BS_STATE3=4, BS_DONE=5, BS_DONE2=6.
- IDLE: a candidate, or a pending slot older than any candidate, is latched (tgt, robid, cndx) -> CAPTURE_MISSPC next cycle.
- CAPTURE_MISSPC (1 cycle):
  - misspc/miss_robid/restore_cndx drive the latched values; branchmiss=1 this cycle only; miss_count++ (saturates at 2^32-1).
  - A strictly older candidate arriving in this cycle replaces the latch and holds the state one more cycle, giving a fresh branchmiss pulse.
  - -> CHKPT_RESTORE.
- CHKPT_RESTORE: restore_req=1 held until restore_ack is sampled high. restore_cndx is stable while req is high. Ack sampled -> CHKPT_RESTORED, and req drops the same edge. An ack arriving with req low is ignored.
- CHKPT_RESTORED: 1 cycle -> STATE3.
- STATE3: wait for advance_pipeline=1 -> DONE. This guarantees the stomp block samples at least one advance inside the stomp window.
- DONE, DONE2: 1 cycle each. DONE2 -> IDLE.
- Misses during CHKPT_RESTORE..DONE2:
  - A candidate younger than miss_robid is discarded (it is already stomped).
  - An older candidate is stored in a one-deep pending slot; an older-still candidate overwrites the slot.
  - The pending entry is consumed from IDLE on the cycle after DONE2; its age is re-evaluated against the current rob_head.
- Minimum miss-to-idle latency: 6 cycles plus ack wait plus advance wait.
- Outputs are registered except busy (decoded from state).

Decomposition:
- QuplsPkg: branch_state_t enum with the encoding above, pc_address_ex_t, RSTPC. Add BS_* only here.
- Sub-module: qupls_rob_age_sel (NBRU-way oldest-select by wrapped ROB age; returns valid, index). It is reused for the pending-vs-candidate comparison.

Test Plan:
1. Single miss: after reset, bru_v=01, bru_miss=01, robid=5, head=0, tgt.pc=0x1000, ack 3 cycles later, advance tied 1 -> branchmiss pulses once 1 cycle later, misspc.pc=0x1000. branch_state walks 1,2,3,4,5,6,0. restore_req is high for exactly the ack-wait span. miss_count=1.
2. Dual miss with wrap: head=30, port0 robid=2, port1 robid=31 -> port1 selected (age 1 < age 4). miss_robid=31, misspc=port1 tgt.
3. Younger miss during restore: active robid=10, head=8, new miss robid=12 in CHKPT_RESTORE -> discarded; no second branchmiss; miss_count unchanged.
4. Older miss during restore: active robid=10, head=8, new miss robid=9 at STATE3 -> pending. After DONE2 -> IDLE for 1 cycle, then CAPTURE with misspc=robid-9 tgt; miss_count=2.
5. Older miss in CAPTURE_MISSPC: robid 10 latched, robid 9 arrives the next cycle -> CAPTURE held 2 cycles, two branchmiss pulses, final misspc=robid-9 tgt.
6. Reset mid-operation: assert rst in CHKPT_RESTORE with req high -> next cycle state=BS_IDLE, restore_req=0, busy=0, pending cleared; an ack after reset causes no transition.
